// File: rtl/sat_enum_solver.sv
// Exhaustive-enumeration 3-SAT solver behind an 8-bit command port; one clause evaluated per cycle.
// Optional eval-cycle statistics counter and READ_STATS command enabled by defining SOLVER_STATS_EN.
module sat_enum_solver #(
    parameter int NVARS    = 8,
    parameter int NCLAUSES = 16,
    parameter int LIT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LIT_W-1:0] bus_a,
    input  logic [LIT_W-1:0] bus_b,
    input  logic [LIT_W-1:0] bus_c,
    input  logic [7:0]       cmd,
    output logic             sat,
    output logic             unsat,
    output logic             busy,
    output logic             err,
    output logic [7:0]       exbus
);

    localparam int CI_W   = (NCLAUSES > 1) ? $clog2(NCLAUSES) : 1;
    localparam int CNT_W  = $clog2(NCLAUSES + 1);
    localparam int NBYTES = (NVARS + 7) / 8;
    localparam int CL_W   = 3 * LIT_W;

    localparam logic [7:0] CMD_CLEAR      = 8'h01;
    localparam logic [7:0] CMD_ADD        = 8'h02;
    localparam logic [7:0] CMD_SOLVE      = 8'h03;
    localparam logic [7:0] CMD_READ       = 8'h04;
    localparam logic [7:0] CMD_ABORT      = 8'h05;
`ifdef SOLVER_STATS_EN
    localparam logic [7:0] CMD_READ_STATS = 8'h06;
`endif

    // DONE_* are decision targets only: the state register goes straight back to IDLE.
    typedef enum logic [1:0] {IDLE, EVAL, DONE_SAT, DONE_UNSAT} state_t;

    state_t             state, state_next;
    logic [CL_W-1:0]    clause_mem [NCLAUSES];
    logic [CNT_W-1:0]   count;
    logic [CI_W-1:0]    ci;
    logic [NVARS-1:0]   asg;
    logic [CL_W-1:0]    cur_clause;
    logic               clause_ok, last_clause;
    logic               do_clear, do_add, add_ok, do_start, ci_inc, asg_inc;
    logic [NBYTES*8-1:0] asg_pad;
    logic [7:0]         rd_byte;

    function automatic logic lit_true(input logic [LIT_W-1:0] lit, input logic [NVARS-1:0] a);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NVARS; i++) begin
            if (lit[LIT_W-2:0] == (LIT_W-1)'(i + 1)) r = a[i] ^ lit[LIT_W-1];
        end
        return r;
    endfunction

    assign cur_clause  = clause_mem[ci];
    assign clause_ok   = lit_true(cur_clause[CL_W-1:2*LIT_W], asg) |
                         lit_true(cur_clause[2*LIT_W-1:LIT_W], asg) |
                         lit_true(cur_clause[LIT_W-1:0], asg);
    assign last_clause = (CNT_W'(ci) == count - CNT_W'(1));
    assign add_ok      = do_add && (count < CNT_W'(NCLAUSES));
    assign busy        = (state == EVAL);

    // cmd is a one-cycle pulse; while EVAL only ABORT and READ(_STATS) are honoured.
    always_comb begin
        state_next = state;
        do_clear   = 1'b0;
        do_add     = 1'b0;
        do_start   = 1'b0;
        ci_inc     = 1'b0;
        asg_inc    = 1'b0;
        case (state)
            IDLE: begin
                case (cmd)
                    CMD_CLEAR: do_clear = 1'b1;
                    CMD_ADD:   do_add   = 1'b1;
                    CMD_SOLVE: begin
                        do_start   = 1'b1;
                        state_next = (count == '0) ? DONE_SAT : EVAL;
                    end
                    default: ;
                endcase
            end
            EVAL: begin
                if (cmd == CMD_ABORT) begin
                    state_next = IDLE;
                end else if (clause_ok) begin
                    if (last_clause) state_next = DONE_SAT;
                    else             ci_inc     = 1'b1;
                end else begin
                    if (&asg) state_next = DONE_UNSAT;
                    else      asg_inc    = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        asg_pad            = '0;
        asg_pad[NVARS-1:0] = asg;
        rd_byte            = 8'h00;
        for (int i = 0; i < NBYTES; i++) begin
            if (bus_a == LIT_W'(i)) rd_byte = asg_pad[8*i +: 8];
        end
    end

`ifdef SOLVER_STATS_EN
    logic [31:0] stats;
    logic [7:0]  stats_byte;

    always_comb begin
        case (bus_a[1:0])
            2'd0:    stats_byte = stats[7:0];
            2'd1:    stats_byte = stats[15:8];
            2'd2:    stats_byte = stats[23:16];
            default: stats_byte = stats[31:24];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || do_clear || do_start) stats <= '0;
        else if (state == EVAL && stats != '1) stats <= stats + 32'd1;
    end
`endif

    always_ff @(posedge clk) begin
        if (add_ok) clause_mem[count[CI_W-1:0]] <= {bus_a, bus_b, bus_c};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
            ci    <= '0;
            asg   <= '0;
            sat   <= 1'b0;
            unsat <= 1'b0;
            err   <= 1'b0;
            exbus <= 8'h00;
        end else begin
            state <= (state_next == DONE_SAT || state_next == DONE_UNSAT) ? IDLE : state_next;
            if (do_clear) begin
                count <= '0;
                asg   <= '0;
                sat   <= 1'b0;
                unsat <= 1'b0;
                err   <= 1'b0;
            end
            if (add_ok)                count <= count + CNT_W'(1);
            else if (do_add)           err   <= 1'b1;
            if (do_start) begin
                sat   <= 1'b0;
                unsat <= 1'b0;
                asg   <= '0;
                ci    <= '0;
            end
            if (ci_inc) ci <= ci + CI_W'(1);
            if (asg_inc) begin
                asg <= asg + NVARS'(1);
                ci  <= '0;
            end
            if (state_next == DONE_SAT)   sat   <= 1'b1;
            if (state_next == DONE_UNSAT) unsat <= 1'b1;
            if (cmd == CMD_READ) exbus <= rd_byte;
`ifdef SOLVER_STATS_EN
            else if (cmd == CMD_READ_STATS) exbus <= stats_byte;
`endif
        end
    end

endmodule

// File: tb/tb_sat_enum_solver.sv
// Directed self-checking bench for sat_enum_solver (NVARS=4, NCLAUSES=2).
module tb_sat_enum_solver;

    logic       clk;
    logic       rst;
    logic [7:0] bus_a, bus_b, bus_c, cmd;
    logic       sat, unsat, busy, err;
    logic [7:0] exbus;

    int checks = 0;
    int passes = 0;

    sat_enum_solver #(.NVARS(4), .NCLAUSES(2), .LIT_W(8)) dut (
        .clk(clk), .rst(rst), .bus_a(bus_a), .bus_b(bus_b), .bus_c(bus_c),
        .cmd(cmd), .sat(sat), .unsat(unsat), .busy(busy), .err(err), .exbus(exbus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    // Called at a negedge; the command is sampled at the next posedge and the task
    // returns at the following negedge, where its effect is visible.
    task automatic do_cmd(input logic [7:0] c, input logic [7:0] a, input logic [7:0] b, input logic [7:0] cc);
        cmd = c; bus_a = a; bus_b = b; bus_c = cc;
        @(negedge clk);
        cmd = 8'h00; bus_a = 8'h00; bus_b = 8'h00; bus_c = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd = 8'h00; bus_a = 8'h00; bus_b = 8'h00; bus_c = 8'h00;
        idle(2);
        rst = 1'b0;
        checks++; if (sat !== 1'b0)    $display("FAIL reset_sat: got %b want 0", sat);       else passes++;
        checks++; if (unsat !== 1'b0)  $display("FAIL reset_unsat: got %b want 0", unsat);   else passes++;
        checks++; if (busy !== 1'b0)   $display("FAIL reset_busy: got %b want 0", busy);     else passes++;
        checks++; if (err !== 1'b0)    $display("FAIL reset_err: got %b want 0", err);       else passes++;
        checks++; if (exbus !== 8'h00) $display("FAIL reset_exbus: got %h want 00", exbus);  else passes++;
    endtask

    task automatic test_sat_single();
        int n;
        do_cmd(8'h01, 8'h00, 8'h00, 8'h00);
        do_cmd(8'h02, 8'h01, 8'h01, 8'h01);
        do_cmd(8'h03, 8'h00, 8'h00, 8'h00);
        checks++; if (busy !== 1'b1) $display("FAIL single_busy_rise: got %b want 1", busy); else passes++;
        wait_done(n);
        checks++; if (n != 2)        $display("FAIL single_busy_cycles: got %0d want 2", n); else passes++;
        checks++; if (sat !== 1'b1)  $display("FAIL single_sat: got %b want 1", sat);        else passes++;
        checks++; if (unsat !== 1'b0) $display("FAIL single_unsat: got %b want 0", unsat);   else passes++;
        do_cmd(8'h04, 8'h01, 8'h00, 8'h00);
        checks++; if (exbus !== 8'h00) $display("FAIL single_read_oob: got %h want 00", exbus); else passes++;
        do_cmd(8'h04, 8'h00, 8'h00, 8'h00);
        checks++; if (exbus !== 8'h01) $display("FAIL single_read0: got %h want 01", exbus);    else passes++;
        do_cmd(8'h06, 8'h00, 8'h00, 8'h00);
`ifdef SOLVER_STATS_EN
        checks++; if (exbus !== 8'h02) $display("FAIL single_stats: got %h want 02", exbus);    else passes++;
`else
        checks++; if (exbus !== 8'h01) $display("FAIL single_cmd06_nop: got %h want 01", exbus); else passes++;
`endif
    endtask

    task automatic test_unsat();
        int n;
        int rises;
        do_cmd(8'h01, 8'h00, 8'h00, 8'h00);
        do_cmd(8'h02, 8'h01, 8'h00, 8'h00);
        do_cmd(8'h02, 8'h81, 8'h00, 8'h00);
        do_cmd(8'h03, 8'h00, 8'h00, 8'h00);
        // even assignments fail clause 0 (1 eval), odd ones fail clause 1 (2 evals)
        wait_done(n);
        checks++; if (n != 24)        $display("FAIL unsat_busy_cycles: got %0d want 24", n); else passes++;
        checks++; if (unsat !== 1'b1) $display("FAIL unsat_flag: got %b want 1", unsat);      else passes++;
        checks++; if (sat !== 1'b0)   $display("FAIL unsat_sat: got %b want 0", sat);         else passes++;
        rises = 0;
        for (int i = 0; i < 4; i++) begin
            if (busy !== 1'b0) rises++;
            @(negedge clk);
        end
        checks++; if (rises != 0)     $display("FAIL unsat_busy_stays_low: got %0d high cycles want 0", rises); else passes++;
        do_cmd(8'h04, 8'h00, 8'h00, 8'h00);
        checks++; if (exbus !== 8'h0f) $display("FAIL unsat_read: got %h want 0f", exbus);   else passes++;
    endtask

    task automatic test_zero_clauses();
        do_cmd(8'h01, 8'h00, 8'h00, 8'h00);
        checks++; if (unsat !== 1'b0) $display("FAIL clear_unsat: got %b want 0", unsat);    else passes++;
        do_cmd(8'h03, 8'h00, 8'h00, 8'h00);
        checks++; if (busy !== 1'b0)  $display("FAIL zero_busy: got %b want 0", busy);       else passes++;
        checks++; if (sat !== 1'b1)   $display("FAIL zero_sat: got %b want 1", sat);         else passes++;
        do_cmd(8'h04, 8'h00, 8'h00, 8'h00);
        checks++; if (exbus !== 8'h00) $display("FAIL zero_read: got %h want 00", exbus);    else passes++;
    endtask

    task automatic test_full();
        int n;
        do_cmd(8'h01, 8'h00, 8'h00, 8'h00);
        do_cmd(8'h02, 8'h01, 8'h01, 8'h01);
        do_cmd(8'h02, 8'h02, 8'h02, 8'h02);
        checks++; if (err !== 1'b0) $display("FAIL full_err_before: got %b want 0", err);    else passes++;
        do_cmd(8'h02, 8'h81, 8'h81, 8'h81);
        checks++; if (err !== 1'b1) $display("FAIL full_err_set: got %b want 1", err);       else passes++;
        // rejected clause (~x1) must not be stored: x1&x2 is satisfiable at 0011
        do_cmd(8'h03, 8'h00, 8'h00, 8'h00);
        wait_done(n);
        checks++; if (n != 6)       $display("FAIL full_busy_cycles: got %0d want 6", n);    else passes++;
        checks++; if (sat !== 1'b1) $display("FAIL full_sat: got %b want 1", sat);           else passes++;
        do_cmd(8'h04, 8'h00, 8'h00, 8'h00);
        checks++; if (exbus !== 8'h03) $display("FAIL full_read: got %h want 03", exbus);    else passes++;
        do_cmd(8'h01, 8'h00, 8'h00, 8'h00);
        checks++; if (err !== 1'b0) $display("FAIL full_err_clear: got %b want 0", err);     else passes++;
        checks++; if (sat !== 1'b0) $display("FAIL full_sat_clear: got %b want 0", sat);     else passes++;
    endtask

    task automatic test_abort();
        do_cmd(8'h01, 8'h00, 8'h00, 8'h00);
        do_cmd(8'h02, 8'h01, 8'h00, 8'h00);
        do_cmd(8'h02, 8'h81, 8'h00, 8'h00);
        do_cmd(8'h03, 8'h00, 8'h00, 8'h00);
        do_cmd(8'h02, 8'h02, 8'h02, 8'h02);
        do_cmd(8'h03, 8'h00, 8'h00, 8'h00);
        idle(2);
        checks++; if (busy !== 1'b1) $display("FAIL abort_busy_before: got %b want 1", busy); else passes++;
        checks++; if (err !== 1'b0)  $display("FAIL abort_add_ignored: got %b want 0", err);  else passes++;
        do_cmd(8'h05, 8'h00, 8'h00, 8'h00);
        checks++; if (busy !== 1'b0)  $display("FAIL abort_busy: got %b want 0", busy);       else passes++;
        idle(3);
        checks++; if (sat !== 1'b0)   $display("FAIL abort_sat: got %b want 0", sat);         else passes++;
        checks++; if (unsat !== 1'b0) $display("FAIL abort_unsat: got %b want 0", unsat);     else passes++;
        // four evals done: a0 c0, a1 c0, a1 c1, a2 c0 -> assignment 3
        do_cmd(8'h04, 8'h00, 8'h00, 8'h00);
        checks++; if (exbus !== 8'h03) $display("FAIL abort_read: got %h want 03", exbus);    else passes++;
    endtask

    task automatic test_rst_mid_solve();
        do_cmd(8'h01, 8'h00, 8'h00, 8'h00);
        do_cmd(8'h02, 8'h01, 8'h00, 8'h00);
        do_cmd(8'h02, 8'h81, 8'h00, 8'h00);
        do_cmd(8'h03, 8'h00, 8'h00, 8'h00);
        idle(2);
        do_cmd(8'h04, 8'h00, 8'h00, 8'h00);
        checks++; if (exbus !== 8'h01) $display("FAIL busy_read: got %h want 01", exbus);     else passes++;
        rst = 1'b1;
        cmd = 8'h03;
        @(negedge clk);
        rst = 1'b0;
        cmd = 8'h00;
        checks++; if (busy !== 1'b0)   $display("FAIL rst_busy: got %b want 0", busy);        else passes++;
        checks++; if (sat !== 1'b0)    $display("FAIL rst_sat: got %b want 0", sat);          else passes++;
        checks++; if (unsat !== 1'b0)  $display("FAIL rst_unsat: got %b want 0", unsat);      else passes++;
        checks++; if (exbus !== 8'h00) $display("FAIL rst_exbus: got %h want 00", exbus);     else passes++;
        do_cmd(8'h03, 8'h00, 8'h00, 8'h00);
        checks++; if (busy !== 1'b0)   $display("FAIL rst_count_busy: got %b want 0", busy);  else passes++;
        checks++; if (sat !== 1'b1)    $display("FAIL rst_count_sat: got %b want 1", sat);    else passes++;
    endtask

    initial begin
        test_reset();
        test_sat_single();
        test_unsat();
        test_zero_clauses();
        test_full();
        test_abort();
        test_rst_mid_solve();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
